// File: rtl/ram_rr_arbiter_100x12.sv
// Two-port round-robin arbiter over a 100x12 single-port RAM, cleared after reset; reads return 1 cycle after grant.
// Grants are combinational pulses; a requester holds req until its gnt, nothing is granted during the clear.
module ram_rr_arbiter_100x12 #(
  parameter int DATA_W = 100,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_err,
  output logic              init_done
);

  localparam logic [0:0]        ST_INIT   = 1'b0;
  localparam logic [0:0]        ST_RUN    = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clrCnt;
  logic              ptrB;
  logic              isRun;
  logic              aInRange;
  logic              bInRange;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWd;
  logic [DATA_W-1:0] mem [DEPTH];

  assign isRun     = (state == ST_RUN);
  assign init_done = isRun;
  assign aInRange  = (a_addr <= LAST_ADDR);
  assign bInRange  = (b_addr <= LAST_ADDR);

  // ptrB set means B owns the tie-break on the next contention cycle
  assign a_gnt = isRun && a_req && (!b_req || !ptrB);
  assign b_gnt = isRun && b_req && (!a_req || ptrB);

  always_comb begin
    memWe   = 1'b0;
    memAddr = clrCnt;
    memWd   = '0;
    if (!isRun) begin
      memWe = 1'b1;
    end else if (a_gnt) begin
      memWe   = a_we && aInRange;
      memAddr = a_addr;
      memWd   = a_din;
    end else if (b_gnt) begin
      memWe   = b_we && bInRange;
      memAddr = b_addr;
      memWd   = b_din;
    end
    memWe = memWe && !rst;
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= memWd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      clrCnt   <= '0;
      ptrB     <= 1'b0;
      a_rvalid <= 1'b0;
      a_err    <= 1'b0;
      a_dout   <= '0;
      b_rvalid <= 1'b0;
      b_err    <= 1'b0;
      b_dout   <= '0;
    end else begin
      if (!isRun) begin
        if (clrCnt == LAST_ADDR) state <= ST_RUN;
        else                     clrCnt <= clrCnt + ADDR_W'(1);
      end
      if (a_gnt)      ptrB <= 1'b1;
      else if (b_gnt) ptrB <= 1'b0;

      a_rvalid <= a_gnt && !a_we;
      a_err    <= a_gnt && !aInRange;
      if (a_gnt && !a_we) a_dout <= aInRange ? mem[a_addr] : '0;

      b_rvalid <= b_gnt && !b_we;
      b_err    <= b_gnt && !bInRange;
      if (b_gnt && !b_we) b_dout <= bInRange ? mem[b_addr] : '0;
    end
  end

endmodule

// File: doc/ram_rr_arbiter_100x12.md
Name: ram_rr_arbiter_100x12

Overview:
Shares one single-port 100-bit x 12-entry RAM between two requesters, A and B. Each requester uses its own req/gnt handshake. Arbitration is round-robin, one access per cycle. After reset the block clears the whole array before it accepts any traffic. Read data comes back registered with one-cycle latency. Out-of-range addresses are flagged.

Parameters:
DATA_W, 100, data width of each RAM word and of din/dout
DEPTH, 12, number of RAM entries; valid addresses are 0..DEPTH-1
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  input  1  single clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
a_req  input  1  requester A access request; held with fields stable until a_gnt
a_we  input  1  A: 1 = write, 0 = read
a_addr  input  ADDR_W  A word address
a_din  input  DATA_W  A write data
a_gnt  output  1  A grant; one-cycle pulse, the access executes at the end of this cycle
a_rvalid  output  1  pulse one cycle after a granted A read
a_dout  output  DATA_W  A read data; holds its value until the next A rvalid
a_err  output  1  pulse one cycle after a granted A access with addr >= DEPTH
b_req, b_we, b_addr, b_din, b_gnt, b_rvalid, b_dout, b_err  (same directions and widths as A, for requester B)
init_done  output  1  high once the clear sequence is complete

Behaviour:
- The design has one clock, clk. Reset rst is synchronous and active-high.
- States:
  - INIT: clear counter cnt runs 0..DEPTH-1; one word written to zero per cycle; no grants issued.
  - RUN: normal arbitration.
- Transitions:
  - rst=1 forces INIT with cnt=0.
  - INIT -> RUN on the cycle after cnt=DEPTH-1 is written, so the clear takes exactly DEPTH cycles.
  - There is no path back to INIT except rst.
- Reset values:
  - gnt, rvalid, err = 0 for both ports.
  - a_dout, b_dout = 0.
  - init_done = 0.
  - Round-robin pointer = A.
- init_done rises in the first RUN cycle and stays high until rst.
- Grant generation is combinational from req, state and pointer, and is asserted only in RUN:
  - Only one requester active: it is granted that cycle.
  - Both active: the pointer owner is granted.
  - After any grant, the pointer moves to the other requester. With no grant, the pointer is unchanged.
  - Never both gnt in the same cycle.
  - Under continuous contention each requester waits at most 1 cycle.
- A requester must keep req and its fields stable until gnt. It deasserts req, or presents a new request, the cycle after gnt. Because gnt is combinational, a req held after gnt is treated as a new request.
- Access on a granted cycle:
  - In-range write: the RAM word is updated at the clock edge.
  - In-range read: the RAM word is sampled at the edge, then dout is updated and rvalid pulses in the next cycle. Latency is 1 cycle.
- Out-of-range access (addr >= DEPTH, i.e. 12..15 at default):
  - The access is granted normally and no RAM change occurs.
  - err pulses in the cycle after gnt.
  - For a read, rvalid also pulses and dout is loaded with 0.
- Read-after-write:
  - A grant in cycle N followed by the other port's read in cycle N+1 returns the data written in N.
  - Same-cycle collisions are impossible, because there is one grant per cycle.
- A write never changes dout or rvalid.
- Reset mid-operation: any pending rvalid/err is dropped, dout is cleared, the pointer returns to A, and the clear sequence restarts.
- A requester holding req during INIT waits; it is not granted until the first RUN cycle.

Test Plan:
- Reset clear:
  - Stimulus: rst for 2 cycles, then release; a_req read addr 5 held from the first cycle.
  - Response: init_done rises exactly 12 cycles after reset release; a_gnt in the first RUN cycle; a_rvalid the next cycle with a_dout=0.
- Single-port write/read:
  - Stimulus: A writes addr 3 = 100'hA5A5...; then A reads addr 3.
  - Response: a_rvalid 1 cycle after the read gnt; a_dout=100'hA5A5...; a_err=0.
- Contention:
  - Stimulus: a_req and b_req held high for 6 cycles, first contention cycle right after reset.
  - Response: grants alternate A,B,A,B,A,B; never both gnt; each waits at most 1 cycle.
- Cross-port read-after-write:
  - Stimulus: B writes addr 11 = 100'h1; A read of addr 11 pending.
  - Response: A is granted the cycle after B's write and returns 100'h1.
- Out of range:
  - Stimulus: A writes addr 12 = all-ones; then B reads addr 15, then B reads addr 0.
  - Response: a_err pulses; b_err and b_rvalid pulse with b_dout=0; the addr-0 read returns its prior contents.
- Reset mid-operation:
  - Stimulus: assert rst in the cycle a_gnt fires for a read.
  - Response: no a_rvalid; a_dout=0; init_done=0; the array reads as all zeros after init_done.
